pwr_seq_n: RTL and testbench
============================

Name: pwr_seq_n

Overview:
- Parametrised N-rail board power sequencer; next generation of the fixed-sequence CPU PMU.
- Drives the ATX enable, rail enables in order, reference-clock enable, CPU POR and PCIe reset.
- Checks each rail's power-good with a timeout and handles faults.
- Services CPU PWR_CTR0/PWR_CTR1 shutdown/reboot requests with reverse-order power-down.

Parameters:
NUM_RAILS, 8, number of sequenced rails (1..32); rail 0 powers up first.
CNT_W, 24, width of the shared delay/timeout counter.
STEP_DLY, 1000, cycles of settle time after a rail's PG goes high, and between rail disables during power-down.
PG_TIMEOUT, 50000, max cycles from rail_en_o[k] rise to synced PG high.
CLK_DLY, 500, cycles from clk_en_o rise to cpu_por_o release.
PCIE_DLY, 2000, cycles from cpu_por_o release to pcie_rst_n_o release.

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
pwr_on_req_i  in  1  level; 1 = board on requested (asynchronous, synchronised internally)
pwr_ctr0_i  in  1  CPU power control 0 (asynchronous)
pwr_ctr1_i  in  1  CPU power control 1 (asynchronous)
rail_pg_i  in  NUM_RAILS  rail power-good (asynchronous)
atx_pwr_o  out  1  ATX supply enable
rail_en_o  out  NUM_RAILS  rail enables
clk_en_o  out  1  CPU reference clock enable
cpu_por_o  out  1  1 = CPU POR released
pcie_rst_n_o  out  1  0 = PCIe held in reset
fault_o  out  1  sticky fault flag
fault_rail_o  out  5  index of the failing rail
state_o  out  4  current FSM state encoding
pwr_flow_done_o  out  1  one-cycle pulse when shutdown completes

Behaviour:
- Reset: all outputs 0; pcie_rst_n_o is 0 (in reset); FSM = OFF; counter = 0. Assertion mid-sequence drops every output immediately (asynchronous).
- All asynchronous inputs pass through 2-flop synchronisers. Their 2-cycle latency counts against PG_TIMEOUT. PWR_CTR edges are detected on the synced values.
- One counter, cleared on every state or rail-index change; increments and saturates at all-ones.
- States: OFF=0, ATX_ON=1, RAIL_UP=2, RAIL_SETTLE=3, CLK_ON=4, POR_WAIT=5, RUN=6, PCIE_HOLD=7, PWR_DN=8, FAULT=9.
- OFF: on synced pwr_on_req=1 and fault_o=0 -> ATX_ON. atx_pwr_o=1 on entry; index k=0.
- ATX_ON: wait STEP_DLY -> RAIL_UP.
- RAIL_UP: rail_en_o[k]=1.
  - synced pg[k]=1 -> RAIL_SETTLE.
  - counter reaches PG_TIMEOUT-1 -> FAULT with fault_rail_o=k.
- RAIL_SETTLE: wait STEP_DLY.
  - If k<NUM_RAILS-1: k++ -> RAIL_UP.
  - Else -> CLK_ON.
- CLK_ON: clk_en_o=1; after CLK_DLY -> POR_WAIT.
- POR_WAIT: cpu_por_o=1; after PCIE_DLY, pcie_rst_n_o=1 -> RUN.
- RUN:
  - Any synced pg[j]=0 -> FAULT with fault_rail_o=j. Lowest index wins if several drop together.
  - Rising edge of synced ctr1 while synced ctr0=1 -> shutdown (PWR_DN, reboot=0).
  - Rising edge of ctr1 while ctr0=0 -> reboot (PWR_DN, reboot=1).
  - pwr_on_req=0 -> shutdown.
  - Priority: fault > pwr_on_req=0 > ctr command.
- Power-up abort: pwr_on_req=0 in ATX_ON..POR_WAIT -> PWR_DN. Only rails already enabled are sequenced down.
- PWR_DN, on entry, same cycle: pcie_rst_n_o=0, cpu_por_o=0, clk_en_o=0.
  - Then, from the highest enabled rail down to 0: clear rail_en_o[k] and wait STEP_DLY. PG is not checked.
  - Then atx_pwr_o=0.
  - Non-reboot: -> OFF with a 1-cycle pwr_flow_done_o.
  - Reboot: -> ATX_ON after STEP_DLY. No done pulse; atx_pwr_o re-asserts.
- FAULT: all rail_en_o, clk_en_o, cpu_por_o, atx_pwr_o and pcie_rst_n_o are 0 in the cycle after detection. fault_o=1 and fault_rail_o are held.
  - Exit only when synced pwr_on_req=0 -> OFF with fault_o cleared. fault_rail_o keeps its last value.
- Simultaneous: a ctr edge in any state other than RUN is ignored. A PG drop during PWR_DN is ignored.

Test Plan:
1. NUM_RAILS=4, STEP_DLY=16, PG_TIMEOUT=256, CLK_DLY=8, PCIE_DLY=32; PG model echoes each enable after 5 cycles; pwr_on_req=1.
   Required: rail_en_o rises 0001, 0011, 0111, 1111 in order, with STEP_DLY settle after each synced PG.
   Required: clk_en_o rises, cpu_por_o follows 8 cycles later, pcie_rst_n_o 32 cycles after that; state_o=6.
2. From RUN: ctr0=1, then ctr1 0->1.
   Required: cpu_por_o, clk_en_o and pcie_rst_n_o drop in the same cycle.
   Required: rails disable 3, 2, 1, 0, each 16 cycles apart; atx_pwr_o drops; pwr_flow_done_o pulses once; state_o=0.
3. From RUN: ctr0=0, ctr1 rising.
   Required: full power-down, then re-power-up to RUN. No done pulse.
4. Rail 2 PG held low.
   Required: FAULT entered exactly PG_TIMEOUT cycles after rail_en_o[2] rise; fault_o=1, fault_rail_o=2, all enables 0.
   Required: pwr_on_req=0 clears fault_o; reasserting pwr_on_req restarts the sequence.
5. In RUN, drop pg[1] and pg[3] in the same cycle.
   Required: fault_rail_o=1, all outputs off.
6. Deassert pwr_on_req while rail 2 settles, and separately assert reset_n_i mid-RAIL_UP.
   Required: abort disables only rails 2, 1, 0, then done pulse.
   Required: the reset case zeroes all outputs asynchronously, and no done pulse follows.

Source files
------------

// File: rtl/pwr_seq_n.sv
// ---------------------------------------------------------------------------
// pwr_seq_n : N-rail board power sequencer
//
// Powers the board up in a fixed order: ATX supply, rails 0..NUM_RAILS-1
// (each checked for power-good within PG_TIMEOUT), reference clock, CPU POR,
// then PCIe reset release. Powers down in reverse order on a CPU PWR_CTR
// shutdown/reboot command, on removal of the power-on request, or on an
// abort mid power-up. Any rail losing power-good in RUN, or a power-up PG
// timeout, latches a fault that is held until the request is removed.
//
// Ports
//   clk_i            system clock
//   reset_n_i        asynchronous active-low reset
//   pwr_on_req_i     board-on request level (async)
//   pwr_ctr0_i       CPU power control 0 (async)
//   pwr_ctr1_i       CPU power control 1 (async)
//   rail_pg_i        per-rail power-good (async)
//   atx_pwr_o        ATX supply enable
//   rail_en_o        per-rail enables
//   clk_en_o         CPU reference clock enable
//   cpu_por_o        1 = CPU POR released
//   pcie_rst_n_o     0 = PCIe held in reset
//   fault_o          sticky fault flag
//   fault_rail_o     index of the failing rail
//   state_o          current FSM state
//   pwr_flow_done_o  one-cycle pulse when a shutdown completes
// ---------------------------------------------------------------------------
module pwr_seq_n #(
  parameter int NUM_RAILS  = 8,
  parameter int CNT_W      = 24,
  parameter int STEP_DLY   = 1000,
  parameter int PG_TIMEOUT = 50000,
  parameter int CLK_DLY    = 500,
  parameter int PCIE_DLY   = 2000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 pwr_on_req_i,
  input  logic                 pwr_ctr0_i,
  input  logic                 pwr_ctr1_i,
  input  logic [NUM_RAILS-1:0] rail_pg_i,
  output logic                 atx_pwr_o,
  output logic [NUM_RAILS-1:0] rail_en_o,
  output logic                 clk_en_o,
  output logic                 cpu_por_o,
  output logic                 pcie_rst_n_o,
  output logic                 fault_o,
  output logic [4:0]           fault_rail_o,
  output logic [3:0]           state_o,
  output logic                 pwr_flow_done_o
);

  typedef enum logic [3:0] {
    ST_OFF         = 4'd0,
    ST_ATX_ON      = 4'd1,
    ST_RAIL_UP     = 4'd2,
    ST_RAIL_SETTLE = 4'd3,
    ST_CLK_ON      = 4'd4,
    ST_POR_WAIT    = 4'd5,
    ST_RUN         = 4'd6,
    ST_PCIE_HOLD   = 4'd7,
    ST_PWR_DN      = 4'd8,
    ST_FAULT       = 4'd9
  } state_t;

  localparam int              SW         = NUM_RAILS + 3;
  localparam logic [CNT_W-1:0] C_STEP_END = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] C_PG_END   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CLK_END  = CNT_W'(CLK_DLY - 1);
  localparam logic [CNT_W-1:0] C_PCIE_END = CNT_W'(PCIE_DLY - 1);
  localparam logic [4:0]       C_LAST     = 5'(NUM_RAILS - 1);

  // One-hot rail mask for a 5-bit rail index (out-of-range index gives 0).
  function automatic logic [NUM_RAILS-1:0] f_onehot(input logic [4:0] idx);
    logic [NUM_RAILS-1:0] v;
    for (int i = 0; i < NUM_RAILS; i++) begin
      v[i] = (5'(i) == idx);
    end
    return v;
  endfunction

  // Registers
  logic [SW-1:0]        r_sync1, r_sync2;
  logic                 r_ctr1_d;
  state_t               r_state;
  logic [4:0]           r_k;
  logic                 r_dn_ph;   // power-down: 0 = rails phase, 1 = ATX-off wait
  logic                 r_reboot;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_atx, r_clk_en, r_por, r_pcie, r_fault, r_done;
  logic [NUM_RAILS-1:0] r_rail_en;
  logic [4:0]           r_fault_rail;

  // Next-state / next-output wires
  state_t               w_state_nxt;
  logic [4:0]           w_k_nxt;
  logic                 w_dn_ph_nxt, w_reboot_nxt;
  logic                 w_atx_nxt, w_clk_en_nxt, w_por_nxt, w_pcie_nxt;
  logic                 w_fault_nxt, w_done_nxt;
  logic [NUM_RAILS-1:0] w_rail_en_nxt;
  logic [4:0]           w_fault_rail_nxt;
  logic                 w_goto_dn, w_goto_fault, w_dn_reboot;

  // Synchronised inputs and derived conditions
  logic                 w_req_s, w_ctr0_s, w_ctr1_s, w_ctr1_rise;
  logic [NUM_RAILS-1:0] w_pg_s;
  logic                 w_pg_k, w_low_any;
  logic [4:0]           w_low_idx;
  logic                 w_step_end, w_cnt_clr;

  assign w_req_s     = r_sync2[SW-1];
  assign w_ctr0_s    = r_sync2[SW-2];
  assign w_ctr1_s    = r_sync2[SW-3];
  assign w_pg_s      = r_sync2[NUM_RAILS-1:0];
  assign w_ctr1_rise = w_ctr1_s & ~r_ctr1_d;
  assign w_step_end  = (r_cnt == C_STEP_END);
  assign w_cnt_clr   = (w_state_nxt != r_state) || (w_k_nxt != r_k) ||
                       (w_dn_ph_nxt != r_dn_ph);

  // Two-flop synchronisers for all asynchronous inputs, plus ctr1 edge history.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_ctr1_d <= 1'b0;
    end else begin
      r_sync1  <= {pwr_on_req_i, pwr_ctr0_i, pwr_ctr1_i, rail_pg_i};
      r_sync2  <= r_sync1;
      r_ctr1_d <= w_ctr1_s;
    end
  end

  // Shared delay/timeout counter: restarts on any state, rail or phase step.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // PG of the rail being brought up, and lowest-index rail with PG low.
  always_comb begin
    w_pg_k    = 1'b0;
    w_low_any = 1'b0;
    w_low_idx = 5'd0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (5'(i) == r_k) begin
        w_pg_k = w_pg_s[i];
      end else begin
        w_pg_k = w_pg_k;
      end
      if (!w_pg_s[i]) begin
        w_low_any = 1'b1;
        w_low_idx = 5'(i);
      end else begin
        w_low_any = w_low_any;
      end
    end
  end

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_dn_ph_nxt      = r_dn_ph;
    w_reboot_nxt     = r_reboot;
    w_atx_nxt        = r_atx;
    w_rail_en_nxt    = r_rail_en;
    w_clk_en_nxt     = r_clk_en;
    w_por_nxt        = r_por;
    w_pcie_nxt       = r_pcie;
    w_fault_nxt      = r_fault;
    w_fault_rail_nxt = r_fault_rail;
    w_done_nxt       = 1'b0;
    w_goto_dn        = 1'b0;
    w_goto_fault     = 1'b0;
    w_dn_reboot      = 1'b0;

    case (r_state)
      ST_OFF: begin
        if (w_req_s && !r_fault) begin
          w_state_nxt = ST_ATX_ON;
          w_atx_nxt   = 1'b1;
          w_k_nxt     = 5'd0;
        end else begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_ATX_ON: begin
        if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (w_step_end) begin
          w_state_nxt   = ST_RAIL_UP;
          w_rail_en_nxt = r_rail_en | f_onehot(r_k);
        end else begin
          w_state_nxt = ST_ATX_ON;
        end
      end
      ST_RAIL_UP: begin
        // A PG arriving on the last allowed cycle still counts as good.
        if (!w_pg_k && (r_cnt == C_PG_END)) begin
          w_goto_fault     = 1'b1;
          w_fault_rail_nxt = r_k;
        end else if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (w_pg_k) begin
          w_state_nxt = ST_RAIL_SETTLE;
        end else begin
          w_state_nxt = ST_RAIL_UP;
        end
      end
      ST_RAIL_SETTLE: begin
        if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (w_step_end && (r_k < C_LAST)) begin
          w_state_nxt   = ST_RAIL_UP;
          w_k_nxt       = r_k + 5'd1;
          w_rail_en_nxt = r_rail_en | f_onehot(r_k + 5'd1);
        end else if (w_step_end) begin
          w_state_nxt  = ST_CLK_ON;
          w_clk_en_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RAIL_SETTLE;
        end
      end
      ST_CLK_ON: begin
        if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (r_cnt == C_CLK_END) begin
          w_state_nxt = ST_POR_WAIT;
          w_por_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_CLK_ON;
        end
      end
      ST_POR_WAIT: begin
        if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (r_cnt == C_PCIE_END) begin
          w_state_nxt = ST_RUN;
          w_pcie_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_POR_WAIT;
        end
      end
      ST_RUN: begin
        if (w_low_any) begin
          w_goto_fault     = 1'b1;
          w_fault_rail_nxt = w_low_idx;
        end else if (!w_req_s) begin
          w_goto_dn = 1'b1;
        end else if (w_ctr1_rise) begin
          // ctr0 high selects shutdown, low selects reboot.
          w_goto_dn   = 1'b1;
          w_dn_reboot = ~w_ctr0_s;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PWR_DN: begin
        if (w_step_end && !r_dn_ph && (r_k != 5'd0)) begin
          w_k_nxt       = r_k - 5'd1;
          w_rail_en_nxt = r_rail_en & ~f_onehot(r_k - 5'd1);
        end else if (w_step_end && !r_dn_ph) begin
          // Rail 0 has had its step delay: drop ATX.
          w_atx_nxt = 1'b0;
          if (r_reboot) begin
            w_dn_ph_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_OFF;
            w_done_nxt  = 1'b1;
          end
        end else if (w_step_end && r_reboot) begin
          w_state_nxt = ST_ATX_ON;
          w_atx_nxt   = 1'b1;
          w_k_nxt     = 5'd0;
          w_dn_ph_nxt = 1'b0;
        end else if (w_step_end) begin
          w_state_nxt = ST_OFF;
          w_done_nxt  = 1'b1;
          w_dn_ph_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_PWR_DN;
        end
      end
      ST_FAULT: begin
        if (!w_req_s) begin
          w_state_nxt = ST_OFF;
          w_fault_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      default: begin
        w_state_nxt   = ST_OFF;
        w_atx_nxt     = 1'b0;
        w_rail_en_nxt = '0;
        w_clk_en_nxt  = 1'b0;
        w_por_nxt     = 1'b0;
        w_pcie_nxt    = 1'b0;
        w_dn_ph_nxt   = 1'b0;
      end
    endcase

    if (w_goto_fault) begin
      w_state_nxt   = ST_FAULT;
      w_atx_nxt     = 1'b0;
      w_rail_en_nxt = '0;
      w_clk_en_nxt  = 1'b0;
      w_por_nxt     = 1'b0;
      w_pcie_nxt    = 1'b0;
      w_fault_nxt   = 1'b1;
    end else if (w_goto_dn) begin
      // Enabled rails are always 0..r_k, so r_k is the highest one to drop.
      w_state_nxt  = ST_PWR_DN;
      w_reboot_nxt = w_dn_reboot;
      w_clk_en_nxt = 1'b0;
      w_por_nxt    = 1'b0;
      w_pcie_nxt   = 1'b0;
      if (|r_rail_en) begin
        w_rail_en_nxt = r_rail_en & ~f_onehot(r_k);
        w_dn_ph_nxt   = 1'b0;
      end else begin
        w_atx_nxt   = 1'b0;
        w_dn_ph_nxt = 1'b1;
      end
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_OFF;
      r_k          <= 5'd0;
      r_dn_ph      <= 1'b0;
      r_reboot     <= 1'b0;
      r_atx        <= 1'b0;
      r_rail_en    <= '0;
      r_clk_en     <= 1'b0;
      r_por        <= 1'b0;
      r_pcie       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_rail <= 5'd0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_dn_ph      <= w_dn_ph_nxt;
      r_reboot     <= w_reboot_nxt;
      r_atx        <= w_atx_nxt;
      r_rail_en    <= w_rail_en_nxt;
      r_clk_en     <= w_clk_en_nxt;
      r_por        <= w_por_nxt;
      r_pcie       <= w_pcie_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_rail <= w_fault_rail_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign atx_pwr_o       = r_atx;
  assign rail_en_o       = r_rail_en;
  assign clk_en_o        = r_clk_en;
  assign cpu_por_o       = r_por;
  assign pcie_rst_n_o    = r_pcie;
  assign fault_o         = r_fault;
  assign fault_rail_o    = r_fault_rail;
  assign state_o         = r_state;
  assign pwr_flow_done_o = r_done;

endmodule

// File: tb/tb_pwr_seq_n.sv
// ---------------------------------------------------------------------------
// tb_pwr_seq_n : directed self-checking bench for pwr_seq_n (4 rails, short
// delays). The PG model echoes each rail enable 5 cycles later; a kill mask
// forces selected PGs low.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwr_seq_n;

  localparam int NR    = 4;
  localparam int STEP  = 16;
  localparam int PGT   = 256;
  localparam int CLKD  = 8;
  localparam int PCIED = 32;
  localparam int ECHO  = 5;
  // rail_en rise -> next rail_en rise: echo + 2 sync + 1 decode + settle
  localparam int RAIL_GAP = ECHO + 2 + 1 + STEP;

  logic          clk = 1'b0;
  logic          reset_n_i, req, ctr0, ctr1;
  logic [NR-1:0] pg, kill;
  logic          atx_pwr_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o, done_o;
  logic [NR-1:0] rail_en_o;
  logic [4:0]    fault_rail_o;
  logic [3:0]    state_o;
  logic [NR-1:0] pipe [ECHO];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  pwr_seq_n #(
    .NUM_RAILS(NR), .CNT_W(24), .STEP_DLY(STEP), .PG_TIMEOUT(PGT),
    .CLK_DLY(CLKD), .PCIE_DLY(PCIED)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .pwr_on_req_i(req),
    .pwr_ctr0_i(ctr0), .pwr_ctr1_i(ctr1), .rail_pg_i(pg),
    .atx_pwr_o(atx_pwr_o), .rail_en_o(rail_en_o), .clk_en_o(clk_en_o),
    .cpu_por_o(cpu_por_o), .pcie_rst_n_o(pcie_rst_n_o), .fault_o(fault_o),
    .fault_rail_o(fault_rail_o), .state_o(state_o), .pwr_flow_done_o(done_o)
  );

  // PG echo model
  always @(posedge clk) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ECHO; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rail_en_o;
      for (int i = 1; i < ECHO; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign pg = pipe[ECHO-1] & ~kill;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_state(input logic [3:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_o === st) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; req = 1'b0; ctr0 = 1'b0; ctr1 = 1'b0; kill = '0;
    repeat (8) @(negedge clk);
    checks++; if ({atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o, done_o} !== 10'd0) begin failures++; $display("FAIL reset_outputs: got %b required all 0", {atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o, done_o}); end
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state_o); end
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL idle_state: got %0d required 0", state_o); end
  endtask

  task automatic test_power_up();
    logic [NR-1:0] exp_v [NR] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [NR-1:0] got_v [NR] = '{default: 4'b0000};
    int rise [NR] = '{default: -1};
    int n_ch = 0, atx_c = -1, clk_c = -1, por_c = -1, pcie_c = -1;
    bit ok = 1'b0;
    logic [NR-1:0] prev = rail_en_o;
    req = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (atx_pwr_o && atx_c < 0) atx_c = cyc;
      if (rail_en_o !== prev) begin
        if (n_ch < NR) begin got_v[n_ch] = rail_en_o; rise[n_ch] = cyc; end
        n_ch++;
        prev = rail_en_o;
      end
      if (clk_en_o && clk_c < 0) clk_c = cyc;
      if (cpu_por_o && por_c < 0) por_c = cyc;
      if (pcie_rst_n_o && pcie_c < 0) pcie_c = cyc;
      if (state_o === 4'd6) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL up_reach_run: state %0d required 6 within budget", state_o); end
    checks++; if (n_ch != NR) begin failures++; $display("FAIL up_rail_steps: got %0d required %0d", n_ch, NR); end
    for (int k = 0; k < NR; k++) begin
      checks++; if (got_v[k] !== exp_v[k]) begin failures++; $display("FAIL up_rail_order[%0d]: got %b required %b", k, got_v[k], exp_v[k]); end
    end
    checks++; if (rise[0] - atx_c != STEP) begin failures++; $display("FAIL up_atx_to_rail0: got %0d required %0d", rise[0] - atx_c, STEP); end
    for (int k = 1; k < NR; k++) begin
      checks++; if (rise[k] - rise[k-1] != RAIL_GAP) begin failures++; $display("FAIL up_rail_gap[%0d]: got %0d required %0d", k, rise[k] - rise[k-1], RAIL_GAP); end
    end
    checks++; if (clk_c - rise[NR-1] != RAIL_GAP) begin failures++; $display("FAIL up_clk_en: got %0d required %0d", clk_c - rise[NR-1], RAIL_GAP); end
    checks++; if (por_c - clk_c != CLKD) begin failures++; $display("FAIL up_por_dly: got %0d required %0d", por_c - clk_c, CLKD); end
    checks++; if (pcie_c - por_c != PCIED) begin failures++; $display("FAIL up_pcie_dly: got %0d required %0d", pcie_c - por_c, PCIED); end
    checks++; if ({atx_pwr_o, fault_o} !== 2'b10) begin failures++; $display("FAIL up_run_flags: got atx/fault %b required 10", {atx_pwr_o, fault_o}); end
  endtask

  task automatic test_shutdown();
    logic [NR-1:0] exp_v [NR] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [NR-1:0] got_v [NR] = '{default: 4'b1111};
    int drop [NR] = '{default: -1};
    int n_ch = 0, por_f = -1, clk_f = -1, pcie_f = -1, atx_f = -1, done_c = -1, n_done = 0;
    logic [3:0] st_done = 4'hF;
    logic [NR-1:0] prev = rail_en_o;
    ctr0 = 1'b1;
    repeat (4) @(negedge clk);
    ctr1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_por_o && por_f < 0) por_f = cyc;
      if (!clk_en_o && clk_f < 0) clk_f = cyc;
      if (!pcie_rst_n_o && pcie_f < 0) pcie_f = cyc;
      if (!atx_pwr_o && atx_f < 0) atx_f = cyc;
      if (rail_en_o !== prev) begin
        if (n_ch < NR) begin got_v[n_ch] = rail_en_o; drop[n_ch] = cyc; end
        n_ch++;
        prev = rail_en_o;
      end
      if (done_o) begin n_done++; done_c = cyc; st_done = state_o; break; end
    end
    @(negedge clk);
    if (done_o) n_done++;
    checks++; if (por_f < 0 || por_f != clk_f || por_f != pcie_f) begin failures++; $display("FAIL dn_same_cycle: por %0d clk %0d pcie %0d required equal", por_f, clk_f, pcie_f); end
    checks++; if (n_ch != NR) begin failures++; $display("FAIL dn_rail_steps: got %0d required %0d", n_ch, NR); end
    for (int k = 0; k < NR; k++) begin
      checks++; if (got_v[k] !== exp_v[k]) begin failures++; $display("FAIL dn_rail_order[%0d]: got %b required %b", k, got_v[k], exp_v[k]); end
    end
    for (int k = 1; k < NR; k++) begin
      checks++; if (drop[k] - drop[k-1] != STEP) begin failures++; $display("FAIL dn_rail_gap[%0d]: got %0d required %0d", k, drop[k] - drop[k-1], STEP); end
    end
    checks++; if (atx_f - drop[NR-1] != STEP) begin failures++; $display("FAIL dn_atx_gap: got %0d required %0d", atx_f - drop[NR-1], STEP); end
    checks++; if (done_c != atx_f) begin failures++; $display("FAIL dn_done_cycle: got %0d required %0d", done_c, atx_f); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL dn_done_count: got %0d required 1", n_done); end
    checks++; if (st_done !== 4'd0) begin failures++; $display("FAIL dn_state_off: got %0d required 0", st_done); end
    ctr0 = 1'b0; ctr1 = 1'b0;
  endtask

  task automatic test_reboot();
    bit ok, saw_dn = 1'b0, back = 1'b0;
    int atx_f = -1, atx_r = -1, n_done = 0;
    wait_state(4'd6, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rb_pre_run: state %0d required 6", state_o); end
    repeat (4) @(negedge clk);
    ctr1 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (state_o === 4'd8) saw_dn = 1'b1;
      if (!atx_pwr_o && atx_f < 0) atx_f = cyc;
      if (atx_pwr_o && atx_f >= 0 && atx_r < 0) atx_r = cyc;
      if (done_o) n_done++;
      if (saw_dn && state_o === 4'd6) begin back = 1'b1; break; end
    end
    checks++; if (!saw_dn) begin failures++; $display("FAIL rb_pwr_dn: state 8 not seen, required"); end
    checks++; if (!back) begin failures++; $display("FAIL rb_back_to_run: state %0d required 6", state_o); end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rb_no_done: got %0d pulses required 0", n_done); end
    checks++; if (atx_f < 0 || atx_r - atx_f != STEP) begin failures++; $display("FAIL rb_atx_off_time: got %0d required %0d", atx_r - atx_f, STEP); end
    checks++; if ({rail_en_o, pcie_rst_n_o} !== 5'b11111) begin failures++; $display("FAIL rb_run_outputs: got %b required 11111", {rail_en_o, pcie_rst_n_o}); end
    ctr1 = 1'b0;
  endtask

  task automatic test_multi_fault();
    bit ok;
    repeat (4) @(negedge clk);
    kill = 4'b1010;
    wait_state(4'd9, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mf_fault: state %0d required 9", state_o); end
    checks++; if (fault_rail_o !== 5'd1) begin failures++; $display("FAIL mf_fault_rail: got %0d required 1", fault_rail_o); end
    checks++; if ({atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o} !== 9'b000000001) begin failures++; $display("FAIL mf_outputs: got %b required 000000001", {atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o}); end
    req = 1'b0; kill = '0;
    wait_state(4'd0, 20, ok);
    checks++; if (!ok || fault_o !== 1'b0) begin failures++; $display("FAIL mf_clear: state %0d fault %b required 0/0", state_o, fault_o); end
  endtask

  task automatic test_pg_timeout();
    bit ok = 1'b0;
    int en2_c = -1, flt_c = -1;
    reset_n_i = 1'b0; req = 1'b0; kill = 4'b0100;
    repeat (10) @(negedge clk);
    reset_n_i = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rail_en_o[2] && en2_c < 0) en2_c = cyc;
      if (state_o === 4'd9) begin flt_c = cyc; ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL to_fault: state %0d required 9", state_o); end
    checks++; if (flt_c - en2_c != PGT) begin failures++; $display("FAIL to_latency: got %0d required %0d", flt_c - en2_c, PGT); end
    checks++; if (fault_rail_o !== 5'd2) begin failures++; $display("FAIL to_fault_rail: got %0d required 2", fault_rail_o); end
    checks++; if ({atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o} !== 9'b000000001) begin failures++; $display("FAIL to_outputs: got %b required 000000001", {atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o}); end
    repeat (10) @(negedge clk);
    checks++; if (state_o !== 4'd9) begin failures++; $display("FAIL to_hold: state %0d required 9", state_o); end
    req = 1'b0;
    wait_state(4'd0, 20, ok);
    checks++; if (!ok || fault_o !== 1'b0) begin failures++; $display("FAIL to_clear: state %0d fault %b required 0/0", state_o, fault_o); end
    checks++; if (fault_rail_o !== 5'd2) begin failures++; $display("FAIL to_rail_kept: got %0d required 2", fault_rail_o); end
    kill = '0;
    req = 1'b1;
    wait_state(4'd6, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_restart: state %0d required 6", state_o); end
  endtask

  task automatic test_abort();
    logic [NR-1:0] exp_v [3] = '{4'b0011, 4'b0001, 4'b0000};
    logic [NR-1:0] got_v [3] = '{default: 4'b1111};
    int drop [3] = '{default: -1};
    int n_ch = 0, n_done = 0, done_c = -1;
    bit ok = 1'b0, rail3 = 1'b0;
    logic [NR-1:0] prev;
    req = 1'b0;
    wait_state(4'd0, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ab_pre_off: state %0d required 0", state_o); end
    req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rail_en_o[3]) rail3 = 1'b1;
      if (state_o === 4'd3 && rail_en_o === 4'b0111) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL ab_reach_settle2: state %0d rails %b required 3/0111", state_o, rail_en_o); end
    req = 1'b0;
    prev = rail_en_o;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rail_en_o[3]) rail3 = 1'b1;
      if (rail_en_o !== prev) begin
        if (n_ch < 3) begin got_v[n_ch] = rail_en_o; drop[n_ch] = cyc; end
        n_ch++;
        prev = rail_en_o;
      end
      if (done_o) begin n_done++; done_c = cyc; break; end
    end
    @(negedge clk);
    if (done_o) n_done++;
    checks++; if (n_ch != 3) begin failures++; $display("FAIL ab_rail_steps: got %0d required 3", n_ch); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got_v[k] !== exp_v[k]) begin failures++; $display("FAIL ab_rail_order[%0d]: got %b required %b", k, got_v[k], exp_v[k]); end
    end
    checks++; if (drop[1] - drop[0] != STEP || drop[2] - drop[1] != STEP) begin failures++; $display("FAIL ab_rail_gap: got %0d,%0d required %0d", drop[1] - drop[0], drop[2] - drop[1], STEP); end
    checks++; if (done_c - drop[2] != STEP) begin failures++; $display("FAIL ab_done_time: got %0d required %0d", done_c - drop[2], STEP); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL ab_done_count: got %0d required 1", n_done); end
    checks++; if (rail3) begin failures++; $display("FAIL ab_rail3: got enabled required never"); end
    checks++; if ({state_o, atx_pwr_o} !== 5'b00000) begin failures++; $display("FAIL ab_off: got state %0d atx %b required 0/0", state_o, atx_pwr_o); end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    int n_done = 0;
    req = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (state_o === 4'd2 && rail_en_o === 4'b0011) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rm_reach_railup: state %0d rails %b required 2/0011", state_o, rail_en_o); end
    reset_n_i = 1'b0;
    req = 1'b0;
    #1;
    checks++; if ({atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o, done_o} !== 10'd0) begin failures++; $display("FAIL rm_async_outputs: got %b required all 0", {atx_pwr_o, rail_en_o, clk_en_o, cpu_por_o, pcie_rst_n_o, fault_o, done_o}); end
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL rm_async_state: got %0d required 0", state_o); end
    @(negedge clk);
    reset_n_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rm_no_done: got %0d pulses required 0", n_done); end
    checks++; if (state_o !== 4'd0) begin failures++; $display("FAIL rm_stays_off: got %0d required 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_shutdown();
    test_reboot();
    test_multi_fault();
    test_pg_timeout();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
